aes_key_expand: RTL and testbench
=================================

// Module: aes_key_expand
// PURPOSE
//  Iterative AES-128 key schedule. It sits upstream of the cipher round datapath and
//  produces round keys 0..NR, one per clock, into an internal key store.
//  The cipher datapath reads round keys from the store by index.
//  SubWord is built from four instances of the existing S-box lookup SubTable.
// PARAMETERS
//  NR      10   number of rounds; round keys 0..NR are generated; legal range 1..10
//  IDX_W   4    width of round-key index; must satisfy 2**IDX_W > NR
// PORTS
//  clk          in   1     single clock; all state updates on posedge
//  rst          in   1     synchronous, active-high reset
//  start        in   1     request expansion of key_in; sampled only when not busy
//  key_in       in   128   cipher key; [127:120] = key byte 0 (FIPS-197 order)
//  busy         out  1     expansion in progress
//  key_ready    out  1     store holds a complete schedule for the last accepted key
//  rk_valid     out  1     one-cycle pulse per newly written round key
//  rk_idx       out  IDX_W index of the key qualified by rk_valid
//  rk           out  128   round key qualified by rk_valid
//  rk_rd_idx    in   IDX_W read address into the key store
//  rk_rd_data   out  128   combinational read; 0 when rk_rd_idx > NR
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, key_ready=0, rk_valid=0, rk_idx=0, rk=0, rcon=8'h01.
//    The store is zeroed, so rk_rd_data=0 for every index.
//  - FSM IDLE -> EXPAND -> IDLE. start with busy=0 is accepted on cycle T.
//    T+1: store[0]=key_in, rk_valid=1, rk_idx=0, rk=key_in, busy=1, key_ready=0.
//    T+1+i (i=1..NR): store[i]=f(store[i-1],rcon_i), rk_valid=1, rk_idx=i.
//    Cycle after key NR is written: busy=0, key_ready=1, rk_valid=0. This gives NR+1
//    consecutive valid pulses.
//  - Round function f, with p = previous key and words p0..p3 (p0 = [127:96]):
//    t  = SubWord(RotWord(p3)) ^ {rcon,24'h0}; RotWord({a,b,c,d}) = {b,c,d,a}
//    w0 = p0^t; w1 = p1^w0; w2 = p2^w1; w3 = p3^w2
//  - rcon starts at 8'h01 for key 1 and advances by xtime after each key
//    (x<<1, ^8'h1b if x[7]): 01,02,04,08,10,20,40,80,1b,36.
//    rcon is reloaded to 8'h01 on accept.
//  - The combinational path per cycle is one S-box plus XORs. The previous-key register
//    feeds f; reading back from the store for f is not permitted.
//  - start while busy=1 is ignored, with no effect on the schedule.
//    start in the same cycle as the final key write is also ignored.
//  - start with key_ready=1 is accepted and clears key_ready at T+1.
//    Store entries not yet rewritten keep their old values until overwritten.
//  - rst mid-expansion aborts next cycle: full reset values apply and partial keys
//    are discarded.
//  - rk_rd_data reflects writes from the next cycle (store is registered, read is comb).
// STRUCTURE
//  - Shared package aes_pkg holds AES_NR_128=10, the RCON_INIT=8'h01 constant and a
//    function xtime(byte).
//  - One natural sub-module, aes_sub_word: 32-bit in and out, built from four SubTable
//    instances. It is reused later by the SubBytes stage.
//  - The top holds the FSM, counter, rcon register, previous-key register and store
//    (reg [127:0] store[0:NR]).
// TESTING
//  1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
//    rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6,
//    11 pulses, busy 11 cycles.
//  2 Zero key: rk1=62636363626363636263636362636363,
//    rk10=b4ef5bcb3e92e21123e951cf6f8f188e; read back all 11 entries via rk_rd_idx.
//  3 start pulsed again at rk_idx=4 with a different key -> ignored; schedule matches
//    test 1 exactly.
//  4 rst asserted at rk_idx=6 -> next cycle busy=0, rk_valid=0, key_ready=0,
//    rk_rd_data=0 for idx 0..15.
//  5 Back-to-back: test 1 key, then start the cycle after key_ready rises with the
//    zero key -> key_ready drops and the test 2 values follow.
//    rk_rd_idx=11..15 returns 0 throughout.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM state type and the GF(2^8) xtime helper.
package aes_pkg;

  localparam int         AES_NR_128 = 10;
  localparam logic [7:0] RCON_INIT  = 8'h01;

  typedef enum logic [0:0] {
    KS_IDLE,
    KS_EXPAND
  } ks_state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/SubTable.sv
// AES forward S-box: one byte in, substituted byte out, purely combinational.
module SubTable (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0 occupies the top byte, so byte a lives at bit offset (255-a)*8 = {~a,3'b0}.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word; combinational, shared with SubBytes.
module aes_sub_word (
  input  logic [31:0] w,
  output logic [31:0] s
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    SubTable u_sub_table (
      .a (w[8*b +: 8]),
      .y (s[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into a store read by index.
// Key 0 appears the cycle after start is accepted, key NR NR cycles later; start is ignored while busy.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR_128,
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [127:0]       key_in,
  output logic               busy,
  output logic               key_ready,
  output logic               rk_valid,
  output logic [IDX_W-1:0]   rk_idx,
  output logic [127:0]       rk,
  input  logic [IDX_W-1:0]   rk_rd_idx,
  output logic [127:0]       rk_rd_data
);

  ks_state_t          state;
  logic [127:0]       store [0:NR];
  logic [127:0]       prev;
  logic [7:0]         rcon;
  logic [IDX_W-1:0]   cnt;

  logic [31:0]        rot;
  logic [31:0]        sub;
  logic [31:0]        t;
  logic [31:0]        w0, w1, w2, w3;
  logic [127:0]       next_key;

  // Round function works from the previous-key register so the path is one S-box deep.
  assign rot = {prev[23:0], prev[31:24]};

  aes_sub_word u_sub_word (
    .w (rot),
    .s (sub)
  );

  assign t        = sub ^ {rcon, 24'h0};
  assign w0       = prev[127:96] ^ t;
  assign w1       = prev[95:64]  ^ w0;
  assign w2       = prev[63:32]  ^ w1;
  assign w3       = prev[31:0]   ^ w2;
  assign next_key = {w0, w1, w2, w3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= KS_IDLE;
      busy      <= 1'b0;
      key_ready <= 1'b0;
      rk_valid  <= 1'b0;
      rk_idx    <= '0;
      rk        <= '0;
      rcon      <= RCON_INIT;
      prev      <= '0;
      cnt       <= '0;
      for (int i = 0; i <= NR; i++) store[i] <= '0;
    end else begin
      case (state)
        KS_IDLE: begin
          rk_valid <= 1'b0;
          if (start) begin
            state     <= KS_EXPAND;
            busy      <= 1'b1;
            key_ready <= 1'b0;
            rk_valid  <= 1'b1;
            rk_idx    <= '0;
            rk        <= key_in;
            store[0]  <= key_in;
            prev      <= key_in;
            rcon      <= RCON_INIT;
            cnt       <= IDX_W'(1);
          end
        end
        KS_EXPAND: begin
          // One extra cycle after key NR keeps busy high while that key is presented.
          if (cnt == IDX_W'(NR + 1)) begin
            state     <= KS_IDLE;
            busy      <= 1'b0;
            key_ready <= 1'b1;
            rk_valid  <= 1'b0;
          end else begin
            store[cnt] <= next_key;
            rk_valid   <= 1'b1;
            rk_idx     <= cnt;
            rk         <= next_key;
            prev       <= next_key;
            rcon       <= xtime(rcon);
            cnt        <= cnt + IDX_W'(1);
          end
        end
        default: state <= KS_IDLE;
      endcase
    end
  end

  assign rk_rd_data = (rk_rd_idx > IDX_W'(NR)) ? '0 : store[rk_rd_idx];

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: stimulus queues expected round keys, a monitor checks each pulse.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         key_ready;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;

  logic [127:0] fips_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic [127:0] zero_rk [0:10] = '{
    128'h00000000000000000000000000000000,
    128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
    128'h90973450696ccffaf2f457330b0fac99,
    128'hee06da7b876a1581759e42b27e91ee2b,
    128'h7f2e2b88f8443e098dda7cbbf34b9290,
    128'hec614b851425758c99ff09376ab49ba7,
    128'h217517873550620bacaf6b3cc61bf09b,
    128'h0ef903333ba9613897060a04511dfa9f,
    128'hb1d4d8e28a7db9da1d7bb3de4c664941,
    128'hb4ef5bcb3e92e21123e951cf6f8f188e
  };

  aes_key_expand dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .key_ready  (key_ready),
    .rk_valid   (rk_valid),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every rk_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rk_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got idx %0d with no expected entry", rk_idx);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rk_idx", {124'h0, rk_idx}, {124'h0, e.idx});
        chk($sformatf("rk[%0d]", e.idx), rk, e.key);
      end
    end
  end

  task automatic check_store_zero(input string nm);
    for (int i = 0; i < 16; i++) begin
      rk_rd_idx = 4'(i);
      #1;
      chk($sformatf("%s_rd[%0d]", nm, i), rk_rd_data, 128'h0);
    end
  endtask

  // kind: 0 plain run, 1 inject a stray start at rk_idx==kidx, 2 assert rst at rk_idx==kidx.
  // Called at a negedge; returns at the negedge where key_ready is first seen (or after abort).
  task automatic run(input logic [127:0] key, input bit use_zero, input int kind, input int kidx);
    int busy_cnt;
    bit done;
    busy_cnt = 0;
    done     = 1'b0;
    for (int i = 0; i <= 10; i++)
      q.push_back('{idx: 4'(i), key: (use_zero ? zero_rk[i] : fips_rk[i])});
    key_in = key;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    key_in    = ~key;
    rk_rd_idx = 4'd11;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      start  = 1'b0;
      key_in = ~key;
      if (c == 0) begin
        chk("key_ready_after_accept", {127'h0, key_ready}, 128'h0);
        chk("busy_after_accept", {127'h0, busy}, 128'h1);
      end
      chk($sformatf("rd_oob[%0d]", rk_rd_idx), rk_rd_data, 128'h0);
      rk_rd_idx = 4'(11 + (c % 5));
      if (busy) busy_cnt++;
      if (kind == 2 && rk_valid && int'(rk_idx) == kidx) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {127'h0, busy}, 128'h0);
        chk("abort_rk_valid", {127'h0, rk_valid}, 128'h0);
        chk("abort_key_ready", {127'h0, key_ready}, 128'h0);
        rst = 1'b0;
        q.delete();
        check_store_zero("abort");
        done = 1'b1;
      end else if (kind == 1 && rk_valid && int'(rk_idx) == kidx) begin
        start  = 1'b1;
        key_in = 128'h000102030405060708090a0b0c0d0e0f;
      end else if (key_ready) begin
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: got key_ready=%0b busy=%0b expected key_ready=1", key_ready, busy);
    end else if (kind != 2) begin
      chk("busy_cycles", 128'(busy_cnt), 128'd11);
      chk("scoreboard_drained", 128'(q.size()), 128'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    key_in    = '0;
    rk_rd_idx = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {127'h0, busy}, 128'h0);
    chk("reset_key_ready", {127'h0, key_ready}, 128'h0);
    chk("reset_rk_valid", {127'h0, rk_valid}, 128'h0);
    chk("reset_rk_idx", {124'h0, rk_idx}, 128'h0);
    chk("reset_rk", rk, 128'h0);
    check_store_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 key
    run(KEY_FIPS, 1'b0, 0, 0);
    chk("fips_key_ready", {127'h0, key_ready}, 128'h1);
    // Zero key, then read every store entry back
    run(KEY_ZERO, 1'b1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      rk_rd_idx = 4'(i);
      #1;
      chk($sformatf("zero_rd[%0d]", i), rk_rd_data, (i <= 10) ? zero_rk[i] : 128'h0);
    end
    // Stray start mid-expansion and on the final key write are both ignored
    @(negedge clk);
    run(KEY_FIPS, 1'b0, 1, 4);
    @(negedge clk);
    run(KEY_FIPS, 1'b0, 1, 9);
    repeat (2) @(negedge clk);
    chk("no_restart_busy", {127'h0, busy}, 128'h0);
    // Reset mid-expansion
    run(KEY_ZERO, 1'b1, 2, 6);
    // Back-to-back: second start issued the cycle key_ready rises
    @(negedge clk);
    run(KEY_FIPS, 1'b0, 0, 0);
    run(KEY_ZERO, 1'b1, 0, 0);
    rk_rd_idx = 4'd1;
    #1;
    chk("b2b_rd[1]", rk_rd_data, zero_rk[1]);
    rk_rd_idx = 4'd10;
    #1;
    chk("b2b_rd[10]", rk_rd_data, zero_rk[10]);

    repeat (3) @(negedge clk);
    chk("final_scoreboard_empty", 128'(q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
